mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory bus between instruction fetch (IF) and the data load/store path (MEM stage, driven by the decoded load/save enables).
- Sequences each transfer through a small FSM, returns read data with a one-cycle valid pulse, and drives stall signals back to the pipeline.
- Enforces a bus timeout.
- Sits between the IF/MEM stages and the memory bus.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max wait cycles for bus_ack before abort (1..255)
- FAIR_LIMIT, 4, consecutive MEM grants allowed while IF waits (only with MEM_ARB_FAIR_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  IF read request; held until if_valid
- if_addr  in  ADDR_W  IF read address
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched word
- mem_req  in  1  MEM request; held until mem_valid
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_valid  out  1  one-cycle pulse: load data ready / store done
- mem_rdata  out  DATA_W  load data (0 for stores)
- bus_req  out  1  bus cycle active
- bus_we  out  1  bus write enable
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_rdata  in  DATA_W  bus read data
- bus_ack  in  1  bus completes cycle
- stall_if  out  1  IF must hold
- stall_mem  out  1  MEM must hold
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst low, asynchronous):
  - FSM to IDLE.
  - All outputs 0: bus_req, bus_we, bus_addr, bus_wdata, both valids, both rdata, bus_err.
  - Wait counter and fairness counter cleared.
  - Reset mid-transfer drops bus_req immediately; the in-flight transfer is discarded with no valid pulse.
- States: IDLE, IF_XFER, MEM_XFER.
- IDLE:
  - A requester whose valid is high this cycle is masked from arbitration.
  - Eligible mem_req wins → MEM_XFER. Latch mem_addr, mem_we, mem_wdata into bus registers.
  - Otherwise eligible if_req → IF_XFER. Latch if_addr; bus_we = 0.
  - Otherwise stay in IDLE.
- XFER states:
  - bus_req = 1; bus_addr, bus_we and bus_wdata are held from the latched registers, independent of requester inputs.
  - Wait counter increments each cycle without bus_ack.
  - On bus_ack in cycle M:
    - Register bus_rdata into the owner's rdata (mem_rdata = 0 if store).
    - Owner's valid = 1 in cycle M+1.
    - FSM = IDLE at M+1; counter cleared.
  - If the counter reaches TIMEOUT without ack: at the next cycle bus_err = 1, owner's valid = 1 with rdata = 0, FSM = IDLE.
  - bus_ack and timeout in the same cycle: ack wins, no bus_err.
- Latency: request at cycle N in IDLE → bus_req at N+1 → valid at ack_cycle+1. Minimum 3 cycles with immediate ack.
- Valid and bus_err are single-cycle pulses. rdata holds until the next valid for that port.
- Stalls (combinational):
  - stall_if = if_req & ~if_valid.
  - stall_mem = mem_req & ~mem_valid.
- bus_ack while in IDLE is ignored.
- Requesters must keep request payload stable until valid. Changes after grant have no effect.

Optional Feature:
- Macro MEM_ARB_FAIR_EN.
- Defined:
  - Fairness counter counts consecutive MEM grants issued while if_req is pending and unmasked.
  - When it equals FAIR_LIMIT, the next IDLE arbitration grants IF even if mem_req is high.
  - Counter clears on any IF grant, or when IF is not requesting.
- Undefined: strict MEM-over-IF priority, no fairness counter logic.

Decomposition:
- Shared package/defines file holds:
  - State encodings ST_IDLE = 2'd0, ST_IF = 2'd1, ST_MEM = 2'd2.
  - Default ADDR_W/DATA_W.
  - Owner encoding OWN_IF/OWN_MEM.
- One sub-module, arb_wait_timer: loadable wait counter with clear, enable and terminal-count output, parameterised by TIMEOUT.
- All else inline.

Test Plan:
- Single IF read: if_req = 1, if_addr = 0x0000_0040; bus acks the first cycle with 0x2409_0005 → bus_req for 1 cycle, if_valid pulse, if_rdata = 0x2409_0005, 3-cycle latency.
- Simultaneous requests: if_req and mem_req (load 0x100) raised together → MEM served first; IF served next; stall_if high throughout the MEM transfer.
- Store with 2 wait states: mem_we = 1, addr 0x200, wdata 0xDEAD_BEEF, ack on the 3rd bus cycle → bus_we = 1 and fields stable all 3 cycles; mem_valid pulse; mem_rdata = 0.
- Timeout: TIMEOUT = 4, bus never acks → exactly 4 wait cycles, bus_err and mem_valid pulse together, rdata = 0, FSM back to IDLE.
- Reset mid-transfer: drop rst during MEM_XFER → bus_req 0 immediately, no valid; after release, pending if_req is granted normally.
- MEM_ARB_FAIR_EN, FAIR_LIMIT = 2: mem_req held high across back-to-back loads with if_req pending → grant order MEM, MEM, IF, MEM.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encodings,
// default bus widths, wait-counter width and transfer-owner encoding.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // Wide enough for the largest supported TIMEOUT (255).
    localparam int unsigned WAIT_CNT_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_IF   = 2'd1;
    localparam logic [1:0] ST_MEM  = 2'd2;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    // Which requester owns the bus in a given transfer state.
    function automatic logic state_owner(input logic [1:0] st);
        return (st == ST_MEM) ? OWN_MEM : OWN_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// arb_wait_timer: loadable bus wait counter with clear and enable.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clr_i           force count to zero (highest priority)
//   ld_i, ld_val_i  load a start value
//   en_i            count one wait cycle
//   tc_o            registered: the count currently equals TIMEOUT-1,
//                   i.e. the cycle in progress is the last allowed wait cycle
module arb_wait_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  ld_i,
    input  logic [WAIT_CNT_W-1:0] ld_val_i,
    input  logic                  en_i,
    output logic                  tc_o
);

    localparam logic [WAIT_CNT_W-1:0] TcVal = WAIT_CNT_W'(TIMEOUT - 1);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  tc_q;

    // Next count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + WAIT_CNT_W'(1);
        end
    end

    // Terminal count is precomputed from the next count so it stays registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            tc_q  <= (TcVal == '0);
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d == TcVal);
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory bus between instruction
// fetch (IF) and the MEM-stage load/store path. MEM has priority; a
// requester whose valid pulse is high is masked for that arbitration cycle.
// Each transfer returns data with a one-cycle valid pulse; a bus that does
// not ack within TIMEOUT cycles is aborted with a bus_err pulse.
// Optional build macro MEM_ARB_FAIR_EN: after FAIR_LIMIT consecutive MEM
// grants with IF waiting, IF is granted next.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_req/if_addr                IF read request (held until if_valid)
//   if_valid/if_rdata             IF response pulse and fetched word
//   mem_req/mem_we/mem_addr/mem_wdata  MEM request (held until mem_valid)
//   mem_valid/mem_rdata           MEM response pulse and load data
//   bus_req/bus_we/bus_addr/bus_wdata  bus cycle outputs
//   bus_rdata/bus_ack             bus response
//   stall_if/stall_mem            combinational pipeline stalls
//   bus_err                       one-cycle pulse on timeout abort
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 255
`ifdef MEM_ARB_FAIR_EN
    ,
    parameter int unsigned FAIR_LIMIT = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    logic [1:0]        state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              mem_valid_q, mem_valid_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              bus_err_q, bus_err_d;

    logic tmr_clr, tmr_ld, tmr_en, tmr_tc;
    logic if_elig, mem_elig, grant_mem, grant_if;

    // A requester is masked during its own valid cycle (request not yet dropped).
    assign if_elig  = if_req  & ~if_valid_q;
    assign mem_elig = mem_req & ~mem_valid_q;

`ifdef MEM_ARB_FAIR_EN
    logic [7:0] fair_q, fair_d;
    logic       fair_force_if;

    assign fair_force_if = (fair_q == 8'(FAIR_LIMIT));
    assign grant_mem     = mem_elig & ~(if_elig & fair_force_if);

    // Consecutive MEM grants taken while IF was waiting.
    always_comb begin
        fair_d = fair_q;
        if (!if_req) begin
            fair_d = '0;
        end else if (state_q == ST_IDLE) begin
            if (grant_if) begin
                fair_d = '0;
            end else if (grant_mem && if_elig) begin
                fair_d = fair_q + 8'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fair_q <= '0;
        end else begin
            fair_q <= fair_d;
        end
    end
`else
    assign grant_mem = mem_elig;
`endif

    assign grant_if = if_elig & ~grant_mem;

    arb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmr_clr),
        .ld_i     (tmr_ld),
        .ld_val_i ('0),
        .en_i     (tmr_en),
        .tc_o     (tmr_tc)
    );

    // Arbitration, transfer sequencing and response generation.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_valid_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = 1'b0;
        tmr_clr     = 1'b0;
        tmr_ld      = 1'b0;
        tmr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_d     = ST_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    tmr_ld      = 1'b1;
                end else if (grant_if) begin
                    state_d     = ST_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    tmr_ld      = 1'b1;
                end
            end

            ST_IF, ST_MEM: begin
                // Ack takes precedence over an expiring wait counter.
                if (bus_ack || tmr_tc) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    tmr_clr   = 1'b1;
                    bus_err_d = ~bus_ack;
                    if (state_owner(state_q) == OWN_MEM) begin
                        mem_valid_d = 1'b1;
                        mem_rdata_d = (bus_ack && !bus_we_q) ? bus_rdata : '0;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus_ack ? bus_rdata : '0;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_rdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            mem_valid_q <= mem_valid_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_err   = bus_err_q;

    assign stall_if  = if_req  & ~if_valid_q;
    assign stall_mem = mem_req & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (TIMEOUT = 4): directed vector table,
// hand-written multi-cycle sequences and a randomized two-requester phase,
// all checked by a negedge bus responder / transaction-level reference.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          mem_valid;
    logic [DW-1:0] mem_rdata;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_ack = 1'b0;
    logic          stall_if;
    logic          stall_mem;
    logic          bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .bus_err   (bus_err)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- bus responder + reference ----------------
    logic          fixed_mode = 1'b1;
    int            fixed_wait = 0;
    logic [DW-1:0] fixed_data = '0;
    logic          noise_en = 1'b0;

    int            bc = 0;
    logic          x_mem = 1'b0, x_we = 1'b0;
    logic [AW-1:0] x_addr = '0;
    logic [DW-1:0] x_wdata = '0, x_data = '0;
    int            x_wait = 0;
    logic          done_pend = 1'b0, done_err = 1'b0, done_mem = 1'b0, was_done;
    logic [DW-1:0] done_rdata = '0;
    logic          p_bus_req = 1'b0, p_if_elig = 1'b0, p_mem_elig = 1'b0, p_mem_we = 1'b0;
    logic [AW-1:0] p_if_addr = '0, p_mem_addr = '0;
    logic [DW-1:0] p_mem_wdata = '0;
    logic          exp_if_v, exp_mem_v;
    logic          grant_log[$];

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            bus_ack    = 1'b0;
            bc         = 0;
            done_pend  = 1'b0;
            p_bus_req  = 1'b0;
            p_if_elig  = 1'b0;
            p_mem_elig = 1'b0;
            continue;
        end
        exp_if_v  = done_pend && !done_mem;
        exp_mem_v = done_pend && done_mem;
        was_done  = done_pend;
        chk("if_valid", if_valid, exp_if_v);
        chk("mem_valid", mem_valid, exp_mem_v);
        chk("bus_err", bus_err, done_pend && done_err);
        if (exp_if_v) chk("if_rdata", if_rdata, done_rdata);
        if (exp_mem_v) chk("mem_rdata", mem_rdata, done_rdata);
        chk("stall_if", stall_if, if_req && !exp_if_v);
        chk("stall_mem", stall_mem, mem_req && !exp_mem_v);
        done_pend = 1'b0;

        // A transfer stays on the bus exactly until it completes.
        if (p_bus_req) chk("bus_req_hold", bus_req, !was_done);
        else if (!bus_req) chk("missed_grant", p_if_elig || p_mem_elig, 1'b0);

        if (bus_req) begin
            if (!p_bus_req) begin
                // Grant decided in the previous (idle) cycle: MEM first.
                x_mem   = p_mem_elig;
                x_addr  = x_mem ? p_mem_addr : p_if_addr;
                x_we    = x_mem && p_mem_we;
                x_wdata = p_mem_wdata;
                x_wait  = fixed_mode ? fixed_wait : int'($urandom_range(0, 5));
                x_data  = fixed_mode ? fixed_data : DW'($urandom);
                bc      = 0;
                grant_log.push_back(x_mem);
            end
            chk("bus_addr", bus_addr, x_addr);
            chk("bus_we", bus_we, x_we);
            if (x_mem) chk("bus_wdata", bus_wdata, x_wdata);
            if (bc == x_wait) begin
                bus_ack    = 1'b1;
                bus_rdata  = x_data;
                done_pend  = 1'b1;
                done_err   = 1'b0;
                done_mem   = x_mem;
                done_rdata = (x_mem && x_we) ? '0 : x_data;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = DW'($urandom);
                if (bc + 1 == int'(TO)) begin
                    done_pend  = 1'b1;
                    done_err   = 1'b1;
                    done_mem   = x_mem;
                    done_rdata = '0;
                end
            end
            bc++;
        end else begin
            bus_ack   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_rdata = DW'($urandom);
        end

        p_bus_req   = bus_req;
        p_if_elig   = if_req && !exp_if_v;
        p_mem_elig  = mem_req && !exp_mem_v;
        p_if_addr   = if_addr;
        p_mem_addr  = mem_addr;
        p_mem_we    = mem_we;
        p_mem_wdata = mem_wdata;
    end

    // ---------------- helpers ----------------
    task automatic wait_valid(input logic is_mem, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!(is_mem ? mem_valid : if_valid) && cyc < 40);
        if (!(is_mem ? mem_valid : if_valid)) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_valid: no valid pulse within %0d cycles (mem=%0d)", cyc, is_mem);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_bus_req"}, bus_req, 1'b0);
        chk({tag, "_bus_we"}, bus_we, 1'b0);
        chk({tag, "_bus_addr"}, bus_addr, '0);
        chk({tag, "_bus_wdata"}, bus_wdata, '0);
        chk({tag, "_if_valid"}, if_valid, 1'b0);
        chk({tag, "_mem_valid"}, mem_valid, 1'b0);
        chk({tag, "_if_rdata"}, if_rdata, '0);
        chk({tag, "_mem_rdata"}, mem_rdata, '0);
        chk({tag, "_bus_err"}, bus_err, 1'b0);
    endtask

    task automatic if_agent(input int n);
        int c;
        for (int k = 0; k < n; k++) begin
            if_addr = AW'($urandom);
            if_req  = 1'b1;
            wait_valid(1'b0, c);
            if ($urandom_range(0, 1) == 1) begin
                if_req = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end
        if_req = 1'b0;
    endtask

    task automatic mem_agent(input int n);
        int c;
        for (int k = 0; k < n; k++) begin
            mem_addr  = AW'($urandom);
            mem_we    = 1'($urandom_range(0, 1));
            mem_wdata = DW'($urandom);
            mem_req   = 1'b1;
            wait_valid(1'b1, c);
            if ($urandom_range(0, 1) == 1) begin
                mem_req = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end
        mem_req = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          is_mem;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            wait_n;
        logic [DW-1:0] bus_data;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    vec_t vt[7];

    initial begin
        int c;
        int nq;

        // is_mem we addr wdata wait bus_data exp_rdata exp_err exp_lat
        vt[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h2409_0005, 32'h2409_0005, 1'b0, 3};
        vt[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h1234_5678, 32'h1234_5678, 1'b0, 4};
        vt[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 2, 32'h5555_AAAA, 32'h0, 1'b0, 5};
        vt[3] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0, 9, 32'h9999_9999, 32'h0, 1'b1, 6};
        vt[4] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 6};
        vt[5] = '{1'b0, 1'b0, 32'h0000_0048, 32'h0, 4, 32'h1111_2222, 32'h0, 1'b1, 6};
        vt[6] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 1'b0, 3};

        #12;
        reset_checks("reset");
        @(posedge clk); #2;
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            fixed_mode = 1'b1;
            fixed_wait = vt[i].wait_n;
            fixed_data = vt[i].bus_data;
            @(posedge clk); #1;
            if (vt[i].is_mem) begin
                mem_we = vt[i].we; mem_addr = vt[i].addr; mem_wdata = vt[i].wdata; mem_req = 1'b1;
            end else begin
                if_addr = vt[i].addr; if_req = 1'b1;
            end
            wait_valid(vt[i].is_mem, c);
            chk($sformatf("vec%0d_latency", i), 64'(c + 1), 64'(vt[i].exp_lat));
            chk($sformatf("vec%0d_rdata", i), vt[i].is_mem ? mem_rdata : if_rdata, vt[i].exp_rdata);
            chk($sformatf("vec%0d_bus_err", i), bus_err, vt[i].exp_err);
            if_req = 1'b0; mem_req = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_err_pulse", i), bus_err, 1'b0);
        end

        // Simultaneous IF + MEM load: MEM first, IF stalled meanwhile.
        grant_log.delete();
        fixed_wait = 0;
        fixed_data = 32'hA5A5_0100;
        @(posedge clk); #1;
        mem_we = 1'b0; mem_addr = 32'h0000_0100; mem_req = 1'b1;
        if_addr = 32'h0000_0080; if_req = 1'b1;
        @(posedge clk); #1;
        chk("sim_stall_if_in_mem", stall_if, 1'b1);
        chk("sim_bus_addr_mem", bus_addr, 32'h0000_0100);
        wait_valid(1'b1, c);
        chk("sim_stall_if_at_mem_valid", stall_if, 1'b1);
        mem_req = 1'b0;
        wait_valid(1'b0, c);
        if_req = 1'b0;
        nq = grant_log.size();
        chk("sim_grant_count", 64'(nq), 64'd2);
        if (nq == 2) begin
            chk("sim_first_mem", grant_log[0], 1'b1);
            chk("sim_second_if", grant_log[1], 1'b0);
        end

        // Reset in the middle of a MEM transfer; pending IF granted afterwards.
        grant_log.delete();
        fixed_wait = 9;
        @(posedge clk); #1;
        mem_we = 1'b0; mem_addr = 32'h0000_0400; mem_req = 1'b1;
        if_addr = 32'h0000_00C0; if_req = 1'b1;
        @(posedge clk); #1;
        chk("rst_seq_busy", bus_req, 1'b1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        reset_checks("midrst");
        mem_req = 1'b0;
        fixed_wait = 0;
        fixed_data = 32'h1357_9BDF;
        @(posedge clk); #2;
        rst = 1'b1;
        wait_valid(1'b0, c);
        chk("rst_seq_if_rdata", if_rdata, 32'h1357_9BDF);
        chk("rst_seq_if_latency", 64'(c), 64'd2);
        if_req = 1'b0;
        nq = grant_log.size();
        chk("rst_seq_grants", 64'(nq), 64'd2);
        if (nq == 2) chk("rst_seq_if_granted", grant_log[1], 1'b0);

        // Randomized traffic from both requesters with random bus latency.
        fixed_mode = 1'b0;
        noise_en   = 1'b1;
        @(posedge clk); #1;
        fork
            if_agent(80);
            mem_agent(80);
        join
        noise_en = 1'b0;
        repeat (10) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
